stream_frame_comparator: RTL and testbench
==========================================

// Module: stream_frame_comparator
// PURPOSE
//   Synthesizable, parametrised successor to the file-based pixel comparator. Joins two
//   valid/ready pixel streams pair by pair: A = DUT output image, B = golden image from
//   ROM/BRAM. Counts matches/mismatches over a frame, captures the first mismatch, and
//   raises done/pass. Sits at the convolution output for on-chip self-check.
// PARAMETERS
//   DATA_W     12                       pixel width in bits
//   FRAME_LEN  4096                     pixel pairs per frame (>=1)
//   CNT_W      $clog2(FRAME_LEN+1)      counter/index width
//   TOL        0                        max |A-B| counted as a match (used only with CMP_ABS_TOL_EN)
// PORTS
//   clk            in   1        rising-edge clock
//   rst_n          in   1        asynchronous active-low reset
//   start          in   1        1-cycle pulse: clear results, begin frame
//   a_valid        in   1        stream A pixel valid
//   a_ready        out  1        stream A accept
//   a_data         in   DATA_W   stream A pixel, unsigned
//   b_valid        in   1        stream B pixel valid
//   b_ready        out  1        stream B accept
//   b_data         in   DATA_W   stream B pixel, unsigned
//   busy           out  1        FSM in RUN
//   done           out  1        frame complete; held until next start
//   pass           out  1        done && mism_cnt==0
//   match_cnt      out  CNT_W    pairs judged equal
//   mism_cnt       out  CNT_W    pairs judged different
//   first_err_vld  out  1        a mismatch has been captured
//   first_err_idx  out  CNT_W    pair index (0-based) of first mismatch
//   first_err_a    out  DATA_W   A value at first mismatch
//   first_err_b    out  DATA_W   B value at first mismatch
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; every output 0, incl. a_ready/b_ready.
//   - FSM: IDLE -start-> RUN; RUN -last pair accepted-> DONE; DONE -start-> RUN.
//     start in RUN restarts: counters/capture cleared, pair index back to 0, stays RUN.
//     A pair accepted in the same cycle as start is discarded.
//   - Join: a_ready = RUN & b_valid; b_ready = RUN & a_valid (combinational).
//     Transfer = RUN & a_valid & b_valid; both streams consume exactly one pixel.
//     One valid without the other: no transfer, nothing consumed, no stall deadlock.
//   - Compare per transfer; results registered on the same edge (1-cycle latency):
//     match -> match_cnt+1; else mism_cnt+1 and, if first_err_vld==0, capture
//     idx/a/b and set first_err_vld. Later mismatches never overwrite the capture.
//   - Pair index counts 0..FRAME_LEN-1. The transfer at index FRAME_LEN-1 moves the FSM to
//     DONE on that edge: done=1 and busy=0 the next cycle. No wrap; counters never exceed
//     FRAME_LEN, so there is no overflow.
//   - In IDLE/DONE, readys are 0 and extra input pixels are ignored (not consumed).
//   - Invariant in DONE: match_cnt + mism_cnt == FRAME_LEN.
//   - start clears done, pass, counters, and first_err_* on the next edge.
// CONFIGURATION
//   CMP_ABS_TOL_EN defined: match iff |a_data-b_data| <= TOL. The difference is computed
//     in DATA_W+1 bits, so there is no wrap at extremes.
//   CMP_ABS_TOL_EN undefined: match iff a_data == b_data. TOL is ignored; no subtractor.
// TESTING
//   1 FRAME_LEN=16, identical ramps 0..15, both valid every cycle -> done after 16 xfers,
//     match_cnt=16, mism_cnt=0, pass=1, first_err_vld=0.
//   2 B[5]=A[5]+1 and B[9]=A[9]^12'hFFF (exact mode) -> mism_cnt=2, first_err_idx=5,
//     first_err_a/b = A[5]/A[5]+1, pass=0.
//   3 Random, independent valid gaps on A and B -> no pixel dropped or duplicated;
//     counts match the scoreboard; a_ready never 1 while b_valid=0.
//   4 CMP_ABS_TOL_EN, TOL=2: pairs (0,2),(4095,4093),(0,3),(4095,0) -> match,match,
//     mismatch,mismatch; mism_cnt=2, first_err_idx=2.
//   5 rst_n=0 at pair 7 mid-frame -> all outputs 0 asynchronously; start then full
//     frame -> clean results. start at pair 7 -> counters 0, index restarts at 0.
//   6 Extra pixels after done -> readys stay 0, counts frozen; second start ->
//     second frame evaluated independently.

Source files
------------

// File: rtl/stream_frame_comparator.sv
// Joins two valid/ready pixel streams pair by pair and scores one frame.
// Optional macro CMP_ABS_TOL_EN: a pair matches when |a-b| <= TOL.
module stream_frame_comparator #(
  parameter int DATA_W    = 12,
  parameter int FRAME_LEN = 4096,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1),
  parameter int TOL       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  mism_cnt,
  output logic              first_err_vld,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_a,
  output logic [DATA_W-1:0] first_err_b
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(FRAME_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] idx;
  logic             xfer;
  logic             last;
  logic             match;

  assign xfer = (state == RUN) && a_valid && b_valid;
  assign last = (idx == LAST_IDX);

`ifdef CMP_ABS_TOL_EN
  localparam logic [DATA_W:0] TOL_V =
    (DATA_W + 1)'(TOL);

  // One extra bit keeps the magnitude exact at the range extremes.
  logic [DATA_W:0] diff;

  assign diff = (a_data >= b_data)
    ? {1'b0, a_data} - {1'b0, b_data}
    : {1'b0, b_data} - {1'b0, a_data};
  assign match = (diff <= TOL_V);
`else
  localparam bit TOL_OK = (TOL >= 0);

  assign match = TOL_OK && (a_data == b_data);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (!start && xfer && last) begin
          state_nxt = DONE;
        end
      end
      DONE: if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign a_ready = busy && b_valid;
  assign b_ready = busy && a_valid;
  assign pass    = done && (mism_cnt == '0);

  // start wins over a coincident transfer, which is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      match_cnt     <= '0;
      mism_cnt      <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      first_err_a   <= '0;
      first_err_b   <= '0;
    end else if (start) begin
      idx           <= '0;
      match_cnt     <= '0;
      mism_cnt      <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      first_err_a   <= '0;
      first_err_b   <= '0;
    end else if (xfer) begin
      idx <= idx + CNT_W'(1);
      if (match) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end else begin
        mism_cnt <= mism_cnt + CNT_W'(1);
        if (!first_err_vld) begin
          first_err_vld <= 1'b1;
          first_err_idx <= idx;
          first_err_a   <= a_data;
          first_err_b   <= b_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_frame_comparator.sv
// Directed bench for stream_frame_comparator with a pair scoreboard.
// Build with +define+CMP_ABS_TOL_EN to exercise tolerance mode.
module tb_stream_frame_comparator;

  localparam int DW  = 12;
  localparam int FL  = 16;
  localparam int CW  = $clog2(FL + 1);
  localparam int TOL = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [DW-1:0] b_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] mism_cnt;
  logic          first_err_vld;
  logic [CW-1:0] first_err_idx;
  logic [DW-1:0] first_err_a;
  logic [DW-1:0] first_err_b;

  stream_frame_comparator #(
    .DATA_W    (DW),
    .FRAME_LEN (FL),
    .TOL       (TOL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_data        (a_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b_data        (b_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .match_cnt     (match_cnt),
    .mism_cnt      (mism_cnt),
    .first_err_vld (first_err_vld),
    .first_err_idx (first_err_idx),
    .first_err_a   (first_err_a),
    .first_err_b   (first_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] pa [FL];
  logic [DW-1:0] pb [FL];
  logic [DW-1:0] exp_a_q [$];
  logic [DW-1:0] exp_b_q [$];
  logic [DW-1:0] mon_ea;
  logic [DW-1:0] mon_eb;
  int            exp_m;
  int            exp_x;
  int            exp_fi;
  logic [DW-1:0] exp_fa;
  logic [DW-1:0] exp_fb;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit is_match(input logic [DW-1:0] a,
                                  input logic [DW-1:0] b);
`ifdef CMP_ABS_TOL_EN
    int d;
    d = int'(a) - int'(b);
    if (d < 0) d = -d;
    return d <= TOL;
`else
    return a == b;
`endif
  endfunction

  // Every accepted pair must be the next one the sources offered.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_ready_wo_b_valid",
          32'(a_ready && !b_valid), 32'd0);
      chk("b_ready_wo_a_valid",
          32'(b_ready && !a_valid), 32'd0);
      if (mon_en && !start && a_valid && a_ready
          && b_valid && b_ready) begin
        if (exp_a_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          mon_ea = exp_a_q.pop_front();
          mon_eb = exp_b_q.pop_front();
          chk("sb_a", 32'(a_data), 32'(mon_ea));
          chk("sb_b", 32'(b_data), 32'(mon_eb));
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_pass"},  32'(pass), 32'd0);
    chk({tag, "_ardy"},  32'(a_ready), 32'd0);
    chk({tag, "_brdy"},  32'(b_ready), 32'd0);
    chk({tag, "_match"}, 32'(match_cnt), 32'd0);
    chk({tag, "_mism"},  32'(mism_cnt), 32'd0);
    chk({tag, "_fvld"},  32'(first_err_vld), 32'd0);
    chk({tag, "_fidx"},  32'(first_err_idx), 32'd0);
    chk({tag, "_fa"},    32'(first_err_a), 32'd0);
    chk({tag, "_fb"},    32'(first_err_b), 32'd0);
  endtask

  task automatic drive_a(input bit gaps);
    bit got;
    for (int i = 0; i < FL; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          a_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      a_valid = 1'b1;
      a_data  = pa[i];
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
        @(negedge clk);
        got = a_ready;
        @(posedge clk); #1;
      end
      if (!got) begin
        chk("a_timeout", 32'd0, 32'd1);
        a_valid = 1'b0;
        return;
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic drive_b(input bit gaps);
    bit got;
    for (int i = 0; i < FL; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          b_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      b_valid = 1'b1;
      b_data  = pb[i];
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
        @(negedge clk);
        got = b_ready;
        @(posedge clk); #1;
      end
      if (!got) begin
        chk("b_timeout", 32'd0, 32'd1);
        b_valid = 1'b0;
        return;
      end
    end
    b_valid = 1'b0;
  endtask

  // Model the frame, stream it, then check results one cycle later.
  task automatic run_frame(input string tag,
                           input bit do_start,
                           input bit gaps);
    bit fv;
    exp_m = 0; exp_x = 0; exp_fi = 0;
    exp_fa = '0; exp_fb = '0; fv = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    for (int i = 0; i < FL; i++) begin
      exp_a_q.push_back(pa[i]);
      exp_b_q.push_back(pb[i]);
      if (is_match(pa[i], pb[i])) begin
        exp_m++;
      end else begin
        exp_x++;
        if (!fv) begin
          fv = 1'b1;
          exp_fi = i;
          exp_fa = pa[i];
          exp_fb = pb[i];
        end
      end
    end
    mon_en = 1'b1;
    if (do_start) pulse_start();
    fork
      drive_a(gaps);
      drive_b(gaps);
    join
    @(negedge clk);
    chk({tag, "_done"},  32'(done), 32'd1);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_pass"},  32'(pass), 32'(exp_x == 0));
    chk({tag, "_match"}, 32'(match_cnt), 32'(exp_m));
    chk({tag, "_mism"},  32'(mism_cnt), 32'(exp_x));
    chk({tag, "_fvld"},  32'(first_err_vld), 32'(fv));
    chk({tag, "_fidx"},  32'(first_err_idx), 32'(exp_fi));
    chk({tag, "_fa"},    32'(first_err_a), 32'(exp_fa));
    chk({tag, "_fb"},    32'(first_err_b), 32'(exp_fb));
    chk({tag, "_sb_left"}, 32'(exp_a_q.size()), 32'd0);
    mon_en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = '0; b_data = '0;
    repeat (2) @(posedge clk); #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_zero("idle");
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;

    // Identical ramps, no gaps.
    for (int i = 0; i < FL; i++) begin
      pa[i] = DW'(i); pb[i] = DW'(i);
    end
    run_frame("t1", 1'b1, 1'b0);
    chk("t1_pass_const", 32'(pass), 32'd1);

    // Two corrupted pairs.
    pb[5] = pa[5] + DW'(1);
    pb[9] = pa[9] ^ 12'hFFF;
    run_frame("t2", 1'b1, 1'b0);

    // Random data, independent gaps on each stream.
    for (int i = 0; i < FL; i++) begin
      pa[i] = DW'($urandom);
      pb[i] = ($urandom_range(0, 3) == 0)
        ? DW'($urandom) : pa[i];
    end
    run_frame("t3", 1'b1, 1'b1);

    // Extremes of the data range.
    for (int i = 0; i < FL; i++) begin
      pa[i] = DW'(i * 7); pb[i] = DW'(i * 7);
    end
    pa[0] = 12'd0;    pb[0] = 12'd2;
    pa[1] = 12'd4095; pb[1] = 12'd4093;
    pa[2] = 12'd0;    pb[2] = 12'd3;
    pa[3] = 12'd4095; pb[3] = 12'd0;
    run_frame("t4", 1'b1, 1'b0);

    // Async reset in the middle of a frame.
    pulse_start();
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_data = DW'(i); b_data = DW'(i);
      @(posedge clk); #1;
    end
    chk("t5_pre_match", 32'(match_cnt), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t5_rst");
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < FL; i++) begin
      pa[i] = DW'(100 + i); pb[i] = DW'(100 + i);
    end
    run_frame("t5_clean", 1'b1, 1'b0);

    // Restart while running at pair 7.
    pulse_start();
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_data = DW'(i); b_data = DW'(i + 100);
      @(posedge clk); #1;
    end
    chk("t5_pre_mism", 32'(mism_cnt), 32'd7);
    a_data = 12'd50; b_data = 12'd999;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("t5_rs_busy",  32'(busy), 32'd1);
    chk("t5_rs_match", 32'(match_cnt), 32'd0);
    chk("t5_rs_mism",  32'(mism_cnt), 32'd0);
    chk("t5_rs_fvld",  32'(first_err_vld), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < FL; i++) begin
      pa[i] = DW'(i * 3); pb[i] = DW'(i * 3);
    end
    pb[3] = pa[3] + DW'(40);
    run_frame("t5_restart", 1'b0, 1'b0);

    // Extra pixels after done are ignored.
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_data = DW'($urandom); b_data = DW'($urandom);
      @(negedge clk);
      chk("t6_ardy",  32'(a_ready), 32'd0);
      chk("t6_brdy",  32'(b_ready), 32'd0);
      chk("t6_done",  32'(done), 32'd1);
      chk("t6_match", 32'(match_cnt), 32'(exp_m));
      chk("t6_mism",  32'(mism_cnt), 32'(exp_x));
      chk("t6_fidx",  32'(first_err_idx), 32'(exp_fi));
      @(posedge clk); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      pa[i] = DW'(4000 + i); pb[i] = DW'(4000 + i);
    end
    pb[12] = 12'd0;
    run_frame("t6_second", 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
